// File: rtl/vga_fb_reader.sv
// vga_fb_reader: scan-out side of the 640x480 3-bit framebuffer.
//   Generates 640x480@60 VGA timing from a pixel tick. It reads one framebuffer
//   pixel per tick and expands the {r,g,b} bits to 24-bit colour. Video, blank
//   and sync leave through registers that share one pipeline delay.
//
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   pix_en             pixel tick; all timing/pipeline state advances only when high
//   mem_raddr/mem_ren  framebuffer read address (y*H_VIS+x) and read enable (= pix_en)
//   mem_rdata          pixel {r,g,b}, valid RD_LAT enabled cycles after its address
//   vga_r/g/b          colour channels, zero outside the visible area
//   vga_hs/vga_vs      active-low syncs
//   vga_blank_n        high during the visible area
//   frame_start        one-clock pulse when the counters wrap to (0,0)
//   cursor_row/col     cursor text cell (CURSOR_OVERLAY_EN builds only)
//
// Build option: define CURSOR_OVERLAY_EN to add a blinking underline cursor.
// The blink runs from a 6-bit frame counter.
module vga_fb_reader #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned RD_LAT = 1
`ifdef CURSOR_OVERLAY_EN
  ,
  parameter int unsigned CHAR_WIDTH  = 20,
  parameter int unsigned CHAR_HEIGHT = 30,
  parameter int unsigned TEXT_Y0     = 270
`endif
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        pix_en,
  output logic [18:0] mem_raddr,
  output logic        mem_ren,
  input  logic [2:0]  mem_rdata,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start
`ifdef CURSOR_OVERLAY_EN
  ,
  input  logic [7:0]  cursor_row,
  input  logic [7:0]  cursor_col
`endif
);

  localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]  H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [18:0] STRIDE   = 19'(H_VIS);
  // One stage for the address register plus RD_LAT for the RAM.
  localparam int unsigned SR_W     = RD_LAT + 1;

  logic [9:0] h_cnt, v_cnt;
  logic       vis, hs_raw, vs_raw;

  logic [SR_W-1:0] vis_sr, hs_sr, vs_sr;
  logic [2:0]      pix;

  assign mem_ren = pix_en;

  // Timing counters. frame_start clears on every clock, stalled or not.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  always_comb begin
    vis    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  end

`ifdef CURSOR_OVERLAY_EN
  logic [7:0]      cur_row_q, cur_col_q;
  logic [5:0]      frame_cnt;
  logic [12:0]     x0, y0, h_w, v_w;
  logic            bar;
  logic [SR_W-1:0] bar_sr;

  // Cursor position is latched once per frame so a mid-frame move never
  // tears the bar.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_row_q <= '0;
      cur_col_q <= '0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      cur_row_q <= cursor_row;
      cur_col_q <= cursor_col;
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  // 13-bit arithmetic covers the largest cell origin (row 255) without wrap;
  // cells off-screen fail the visible term and draw nothing.
  always_comb begin
    h_w = {3'b000, h_cnt};
    v_w = {3'b000, v_cnt};
    x0  = 13'(cur_col_q) * 13'(CHAR_WIDTH);
    y0  = 13'(TEXT_Y0) + 13'(cur_row_q) * 13'(CHAR_HEIGHT);
    bar = vis && frame_cnt[5] &&
          (h_w >= x0) && (h_w < x0 + 13'(CHAR_WIDTH)) &&
          (v_w >= y0 + 13'(CHAR_HEIGHT - 3)) && (v_w < y0 + 13'(CHAR_HEIGHT));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bar_sr <= '0;
    end else if (pix_en) begin
      bar_sr <= {bar_sr[SR_W-2:0], bar};
    end
  end

  always_comb begin
    pix = mem_rdata;
    if (bar_sr[SR_W-1]) pix = 3'b111;
  end
`else
  always_comb begin
    pix = mem_rdata;
  end
`endif

  // Stage 1: address register, with control flags entering their delay line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_raddr <= '0;
      vis_sr    <= '0;
      hs_sr     <= '1;
      vs_sr     <= '1;
    end else if (pix_en) begin
      mem_raddr <= vis ? (19'(v_cnt) * STRIDE + 19'(h_cnt)) : '0;
      vis_sr    <= {vis_sr[SR_W-2:0], vis};
      hs_sr     <= {hs_sr[SR_W-2:0], hs_raw};
      vs_sr     <= {vs_sr[SR_W-2:0], vs_raw};
    end
  end

  // Output stage: video and syncs leave the same register bank.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga_r       <= vis_sr[SR_W-1] ? {8{pix[2]}} : '0;
      vga_g       <= vis_sr[SR_W-1] ? {8{pix[1]}} : '0;
      vga_b       <= vis_sr[SR_W-1] ? {8{pix[0]}} : '0;
      vga_blank_n <= vis_sr[SR_W-1];
      vga_hs      <= hs_sr[SR_W-1];
      vga_vs      <= vs_sr[SR_W-1];
    end
  end

endmodule
